// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath.
//
// Signals
//   opcode, funct, zero      : datapath -> controller (instruction fields, ALU zero flag)
//   pc_en .. alu_src_a       : single-bit datapath controls
//   alu_src_b, pc_src        : 2-bit mux selects
//   alu_ctrl                 : ALU operation code (ALU_CTRL_W bits)
//   state_out                : current controller state, for observation
//   illegal_op               : one-cycle flag for an unsupported opcode/funct
// Modports
//   master : the controller
//   slave  : the datapath
interface multicycle_ctrl_if #(
    parameter int ALU_CTRL_W = 3
);
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  zero;
    logic                  pc_en;
    logic                  ir_write;
    logic                  reg_write;
    logic                  mem_write;
    logic                  iord;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            pc_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [3:0]            state_out;
    logic                  illegal_op;

    modport master (
        input  opcode, funct, zero,
        output pc_en, ir_write, reg_write, mem_write, iord, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_ctrl,
               state_out, illegal_op
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, ir_write, reg_write, mem_write, iord, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_ctrl,
               state_out, illegal_op
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller (Moore FSM).
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous active-high reset; while high, the write/load strobes
//         and illegal_op are held low and the remaining controls show FETCH
//   bus : multicycle_ctrl_if.master (opcode/funct/zero in, controls out)
//
// Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq, addi.
// Optional: define MULTICYCLE_JUMP_EN to add the j instruction (JUMP state).
// Without it, opcode 000010 is flagged illegal and state code 11 is unused.
module multicycle_ctrl #(
    parameter int ALU_CTRL_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
`ifdef MULTICYCLE_JUMP_EN
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
`else
        S_ADDIWB = 4'd10
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b111);

    state_t state_reg;
    state_t state_next;
    state_t dec_state;   // state used for output decode (FETCH while in reset)

    logic pc_write;
    logic branch;
    logic illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        // Next-state logic
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J:         state_next = S_JUMP;
`endif
                    default:      state_next = S_FETCH;
                endcase
            end
            // opcode is sampled live here; anything that is no longer a
            // load/store abandons the access rather than guessing.
            S_MEMADR: begin
                if (bus.opcode == OP_LW) begin
                    state_next = S_MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    state_next = S_MEMWR;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMRD:  state_next = S_MEMWB;
            S_EXEC:   state_next = S_ALUWB;
            S_ADDIEX: state_next = S_ADDIWB;
            default:  state_next = S_FETCH;   // write-back states and codes 11..15
        endcase

        // Output decode
        dec_state       = rst ? S_FETCH : state_reg;
        pc_write        = 1'b0;
        branch          = 1'b0;
        illegal         = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.mem_write   = 1'b0;
        bus.iord        = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.pc_src      = 2'b00;
        bus.alu_ctrl    = ALU_ADD;
        case (dec_state)
            S_FETCH: begin
                bus.ir_write  = 1'b1;
                pc_write      = 1'b1;
                bus.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: illegal = 1'b0;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J:    illegal = 1'b0;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: bus.iord = 1'b1;
            S_MEMWR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                case (bus.funct)
                    6'b100000: bus.alu_ctrl = ALU_ADD;
                    6'b100010: bus.alu_ctrl = ALU_SUB;
                    6'b100100: bus.alu_ctrl = ALU_AND;
                    6'b100101: bus.alu_ctrl = ALU_OR;
                    6'b101010: bus.alu_ctrl = ALU_SLT;
                    default:   illegal      = 1'b1;
                endcase
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_ADDIWB: bus.reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_ctrl  = ALU_SUB;
                branch        = 1'b1;
                bus.pc_src    = 2'b01;
            end
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP: begin
                pc_write   = 1'b1;
                bus.pc_src = 2'b10;
            end
`endif
            default: ;
        endcase

        bus.pc_en      = pc_write | (branch & bus.zero);
        bus.illegal_op = illegal;

        // Reset suppresses every strobe that could change architectural state.
        if (rst) begin
            bus.pc_en      = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.mem_write  = 1'b0;
            bus.illegal_op = 1'b0;
        end
    end

    assign bus.state_out = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    logic clk;
    logic rst;

    multicycle_ctrl_if #(.ALU_CTRL_W(3)) bus ();

    multicycle_ctrl #(.ALU_CTRL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] vec;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Packed view: {state[3:0], pc_en, ir_write, reg_write, mem_write, iord,
    //               reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0],
    //               pc_src[1:0], alu_ctrl[2:0], illegal_op}
    function automatic logic [19:0] dut_vec();
        return {bus.state_out, bus.pc_en, bus.ir_write, bus.reg_write,
                bus.mem_write, bus.iord, bus.reg_dst, bus.mem_to_reg,
                bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.alu_ctrl,
                bus.illegal_op};
    endfunction

    // Reference table of control outputs for a given state and inputs.
    function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic r,
                                            input logic [5:0] op, input logic [5:0] fn,
                                            input logic z);
        logic [3:0] s;
        logic pcw, br, irw, rw, mw, io, rd, mtr, sa, ill;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        s = r ? 4'd0 : st;
        {pcw, br, irw, rw, mw, io, rd, mtr, sa, ill} = '0;
        sb = 2'b00; ps = 2'b00; ac = 3'b010;
        if (s == 4'd0) begin irw = 1; pcw = 1; sb = 2'b01; end
        if (s == 4'd1) begin
            sb = 2'b11;
            ill = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                    op == 6'b000100 || op == 6'b001000
`ifdef MULTICYCLE_JUMP_EN
                    || op == 6'b000010
`endif
                    );
        end
        if (s == 4'd2 || s == 4'd9) begin sa = 1; sb = 2'b10; end
        if (s == 4'd3) io = 1;
        if (s == 4'd4) begin rw = 1; mtr = 1; end
        if (s == 4'd5) begin io = 1; mw = 1; end
        if (s == 4'd6) begin
            sa = 1;
            if (fn == 6'b100010) ac = 3'b110;
            else if (fn == 6'b100100) ac = 3'b000;
            else if (fn == 6'b100101) ac = 3'b001;
            else if (fn == 6'b101010) ac = 3'b111;
            else if (fn != 6'b100000) ill = 1;
        end
        if (s == 4'd7) begin rw = 1; rd = 1; end
        if (s == 4'd10) rw = 1;
        if (s == 4'd8) begin sa = 1; ac = 3'b110; br = 1; ps = 2'b01; end
`ifdef MULTICYCLE_JUMP_EN
        if (s == 4'd11) begin pcw = 1; ps = 2'b10; end
`endif
        if (r) begin
            return {st, 1'b0, 1'b0, 1'b0, 1'b0, io, rd, mtr, sa, sb, ps, ac, 1'b0};
        end
        return {st, pcw | (br & z), irw, rw, mw, io, rd, mtr, sa, sb, ps, ac, ill};
    endfunction

    // One clock: push the expectation for the current inputs, compare at the
    // falling edge, then move to just after the next rising edge.
    task automatic cycle(input logic [3:0] st, input string tag);
        exp_t e;
        exp_t got;
        logic [19:0] act;
        e.vec = exp_vec(st, rst, bus.opcode, bus.funct, bus.zero);
        e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        act = dut_vec();
        n_checks++;
        if (act !== got.vec) begin
            $display("FAIL %s state=%0d: got %05h expected %05h", got.tag, st, act, got.vec);
        end else begin
            n_pass++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.opcode = 6'b111111;
        bus.funct = 6'b000000;
        bus.zero = 1'b0;
        @(posedge clk);
        #1;
        cycle(4'd0, "reset_hold1");
        cycle(4'd0, "reset_hold2");
        rst = 1'b0;
        cycle(4'd0, "reset_release");
        cycle(4'd1, "illegal_opcode");
        $display("txn reset + illegal opcode 111111");
    endtask

    task automatic test_lw();
        bus.opcode = 6'b100011;
        cycle(4'd0, "lw_fetch");
        cycle(4'd1, "lw_decode");
        cycle(4'd2, "lw_memadr");
        cycle(4'd3, "lw_memrd");
        cycle(4'd4, "lw_memwb");
        $display("txn lw");
    endtask

    task automatic test_sw();
        bus.opcode = 6'b101011;
        cycle(4'd0, "sw_fetch");
        cycle(4'd1, "sw_decode");
        cycle(4'd2, "sw_memadr");
        cycle(4'd5, "sw_memwr");
        $display("txn sw");
    endtask

    task automatic test_rtype(input logic [5:0] fn, input string name);
        bus.opcode = 6'b000000;
        bus.funct = fn;
        cycle(4'd0, {name, "_fetch"});
        cycle(4'd1, {name, "_decode"});
        cycle(4'd6, {name, "_exec"});
        cycle(4'd7, {name, "_aluwb"});
        $display("txn rtype %s funct=%b", name, fn);
    endtask

    task automatic test_addi();
        bus.opcode = 6'b001000;
        cycle(4'd0, "addi_fetch");
        cycle(4'd1, "addi_decode");
        cycle(4'd9, "addi_exec");
        cycle(4'd10, "addi_wb");
        $display("txn addi");
    endtask

    task automatic test_branch(input logic z);
        bus.opcode = 6'b000100;
        bus.zero = z;
        cycle(4'd0, "beq_fetch");
        cycle(4'd1, "beq_decode");
        cycle(4'd8, z ? "beq_taken" : "beq_not_taken");
        bus.zero = 1'b0;
        $display("txn beq zero=%0b", z);
    endtask

    task automatic test_jump();
        bus.opcode = 6'b000010;
        cycle(4'd0, "j_fetch");
        cycle(4'd1, "j_decode");
`ifdef MULTICYCLE_JUMP_EN
        cycle(4'd11, "j_jump");
`endif
        $display("txn j");
    endtask

    task automatic test_reset_mid();
        bus.opcode = 6'b101011;
        cycle(4'd0, "rstmid_fetch");
        cycle(4'd1, "rstmid_decode");
        rst = 1'b1;
        cycle(4'd2, "rstmid_memadr_rst");
        rst = 1'b0;
        cycle(4'd0, "rstmid_refetch");
        cycle(4'd1, "rstmid_decode2");
        cycle(4'd2, "rstmid_memadr2");
        cycle(4'd5, "rstmid_memwr2");
        $display("txn sw with mid-instruction reset");
    endtask

    task automatic test_back_to_back();
        test_lw();
        test_branch(1'b1);
        test_addi();
        cycle(4'd0, "b2b_final_fetch");
        $display("txn back-to-back tail");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_rtype(6'b101010, "slt");
        test_rtype(6'b100010, "sub");
        test_rtype(6'b100100, "and");
        test_rtype(6'b100101, "or");
        test_rtype(6'b111111, "badfunct");
        test_branch(1'b1);
        test_branch(1'b0);
        test_addi();
        test_sw();
        test_jump();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
